// File: rtl/quotient_div_pkg.sv
//------------------------------------------------------------------------------
// Module   : div_pkg
// Brief    : Shared types and helpers for the quotient_div iterative divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter width able to hold value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        return is_signed ? ((64'd1 << (width - 1)) - 64'd1) : ((64'd1 << width) - 64'd1);
    endfunction

    // Bit pattern of the most negative value (zero for unsigned operands).
    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        return is_signed ? (64'd1 << (width - 1)) : 64'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/quotient_div_if.sv
//------------------------------------------------------------------------------
// Module   : quotient_div_if
// Brief    : Operand/result handshake bundle for quotient_div.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface quotient_div_if #(
    parameter int NSIZE = 32,
    parameter int DSIZE = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [NSIZE-1:0] n;
    logic [DSIZE-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [NSIZE-1:0] q;
    logic [DSIZE-1:0] r;
    logic             div_zero;
    logic             ovf;

    modport master (
        output in_valid, n, d, out_ready,
        input  in_ready, out_valid, q, r, div_zero, ovf
    );

    modport slave (
        input  in_valid, n, d, out_ready,
        output in_ready, out_valid, q, r, div_zero, ovf
    );
endinterface

`default_nettype wire

// File: rtl/quotient_div_step.sv
//------------------------------------------------------------------------------
// Module   : div_step
// Brief    : Combinational single restoring-division step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step #(
    parameter int DSIZE = 16
) (
    input  wire  [DSIZE:0]   i_rem,
    input  wire              i_bit,
    input  wire  [DSIZE-1:0] i_dabs,
    output logic [DSIZE:0]   o_rem,
    output logic             o_qbit
);
    logic [DSIZE:0] w_shift;

    // Incoming remainder is always below |d|, so its top bit can be dropped.
    assign w_shift = {i_rem[DSIZE-1:0], i_bit};
    assign o_qbit  = (w_shift >= {1'b0, i_dabs});
    assign o_rem   = o_qbit ? (w_shift - {1'b0, i_dabs}) : w_shift;
endmodule

`default_nettype wire

// File: rtl/quotient_div.sv
//------------------------------------------------------------------------------
// Module   : quotient_div
// Brief    : Iterative signed/unsigned restoring divider, one quotient bit per
//            enabled cycle. Define QUOT_ROUND_EN for round-half-away-from-zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module quotient_div
    import div_pkg::*;
#(
    parameter int NSIZE  = 32,
    parameter int DSIZE  = 16,
    parameter bit SIGNED = 1'b1
) (
    input wire            clk,
    input wire            rst_n,
    input wire            ce,
    quotient_div_if.slave bus
);
    localparam int               c_CNT_W = clog2(NSIZE);
    localparam logic [NSIZE-1:0] c_QMAX  = NSIZE'(sat_max(NSIZE, SIGNED));
    localparam logic [NSIZE-1:0] c_QMIN  = NSIZE'(sat_min(NSIZE, SIGNED));

    state_t               r_state;
    state_t               w_next;
    logic [NSIZE-1:0]     r_nq;
    logic [DSIZE:0]       r_rem;
    logic [DSIZE-1:0]     r_dabs;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sq;
    logic                 r_sr;
    logic                 r_dz;
    logic [NSIZE-1:0]     r_q;
    logic [DSIZE-1:0]     r_r;
    logic                 r_div_zero;
    logic                 r_ovf;

    logic                 w_nneg;
    logic                 w_dneg;
    logic [NSIZE-1:0]     w_nabs;
    logic [DSIZE-1:0]     w_dabs;
    logic                 w_dzero;
    logic [DSIZE:0]       w_step_rem;
    logic                 w_qbit;
    logic [DSIZE-1:0]     w_mag_r;
    logic [NSIZE:0]       w_mag_ext;
    logic [NSIZE:0]       w_limit;
    logic                 w_ovf;
    logic [NSIZE-1:0]     w_q_fix;
    logic [DSIZE-1:0]     w_r_fix;
`ifdef QUOT_ROUND_EN
    logic                 w_round;
`endif

    generate
        if (SIGNED) begin : g_signed
            assign w_nneg = bus.n[NSIZE-1];
            assign w_dneg = bus.d[DSIZE-1];
        end else begin : g_unsigned
            assign w_nneg = 1'b0;
            assign w_dneg = 1'b0;
        end
    endgenerate

    // Negating the most negative dividend yields 2^(NSIZE-1) read as unsigned.
    assign w_nabs  = w_nneg ? ((~bus.n) + NSIZE'(1)) : bus.n;
    assign w_dabs  = w_dneg ? ((~bus.d) + DSIZE'(1)) : bus.d;
    assign w_dzero = (bus.d == '0);

    div_step #(
        .DSIZE (DSIZE)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_nq[NSIZE-1]),
        .i_dabs (r_dabs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (ce && bus.in_valid) w_next = w_dzero ? FIX : CALC;
            CALC: if (ce && (r_cnt == '0)) w_next = FIX;
            FIX:  if (ce) w_next = DONE;
            DONE: if (ce && bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_mag_r   = r_rem[DSIZE-1:0];
        w_mag_ext = {1'b0, r_nq};
`ifdef QUOT_ROUND_EN
        w_round   = ({w_mag_r, 1'b0} >= {1'b0, r_dabs});
        if (w_round) begin
            w_mag_ext = {1'b0, r_nq} + (NSIZE+1)'(1);
        end
`endif
        // Negative quotients may reach one past the positive maximum.
        w_limit = r_sq ? {1'b0, c_QMIN} : {1'b0, c_QMAX};
        w_ovf   = (w_mag_ext > w_limit);
        w_r_fix = r_sr ? (-w_mag_r) : w_mag_r;
`ifdef QUOT_ROUND_EN
        if (w_round && !w_ovf) begin
            w_r_fix = r_sr ? (r_dabs - w_mag_r) : (w_mag_r - r_dabs);
        end
`endif
        if (r_dz) begin
            w_q_fix = r_sr ? c_QMIN : c_QMAX;
            w_r_fix = r_rem[DSIZE-1:0];
        end else if (w_ovf) begin
            w_q_fix = r_sq ? c_QMIN : c_QMAX;
        end else begin
            w_q_fix = r_sq ? (-w_mag_ext[NSIZE-1:0]) : w_mag_ext[NSIZE-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nq       <= '0;
            r_rem      <= '0;
            r_dabs     <= '0;
            r_cnt      <= '0;
            r_sq       <= 1'b0;
            r_sr       <= 1'b0;
            r_dz       <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (ce) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_nq   <= w_nabs;
                        r_dabs <= w_dabs;
                        r_sq   <= w_nneg ^ w_dneg;
                        r_sr   <= w_nneg;
                        r_dz   <= w_dzero;
                        r_cnt  <= c_CNT_W'(NSIZE - 1);
                        // A zero divisor skips CALC; park n's low bits as the remainder.
                        r_rem  <= w_dzero ? {1'b0, bus.n[DSIZE-1:0]} : '0;
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_nq  <= {r_nq[NSIZE-2:0], w_qbit};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                FIX: begin
                    r_q        <= w_q_fix;
                    r_r        <= w_r_fix;
                    r_div_zero <= r_dz;
                    r_ovf      <= ~r_dz & w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.q         = r_q;
    assign bus.r         = r_r;
    assign bus.div_zero  = r_div_zero;
    assign bus.ovf       = r_ovf;
endmodule

`default_nettype wire

// File: doc/quotient_div.md
# quotient_div

Iterative signed divider: the inverse companion of the pipelined product multiplier in the audio datapath. It divides a PSIZE-wide product-domain value by a sample-width divisor. Typical uses are gain normalisation and level-meter averaging ahead of the WM8731 DAC path. It produces one quotient bit per enabled cycle (restoring algorithm) behind a valid/ready handshake.

## Interface
Parameters:
- NSIZE, 32, dividend and quotient width.
- DSIZE, 16, divisor and remainder width (DSIZE ≤ NSIZE).
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable. When low, all state, counters and outputs freeze.
- in_valid  in  1  operands valid.
- in_ready  out  1  high only in IDLE.
- n  in  NSIZE  dividend.
- d  in  DSIZE  divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- q  out  NSIZE  quotient.
- r  out  DSIZE  remainder.
- div_zero  out  1  d was 0 (qualified by out_valid).
- ovf  out  1  quotient saturated (qualified by out_valid).

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset state is IDLE. Reset values: in_ready=1; out_valid, q, r, div_zero and ovf are all 0.
- IDLE → CALC on in_valid & ce. The accept cycle latches |n|, |d|, sign_q = n_msb^d_msb and sign_r = n_msb. Signs are forced to 0 when SIGNED=0.
- IDLE → FIX directly if d==0.
- CALC: one restoring step per ce cycle, MSB first. The partial remainder is DSIZE+1 bits, with compare/subtract against |d|. A bit counter runs NSIZE-1 down to 0, then the FSM moves to FIX.
- FIX: applies signs, saturation and rounding, registers q/r/flags, then moves to DONE.
- DONE: out_valid=1. On out_ready & ce, moves to IDLE; out_valid drops the next cycle.
- Arithmetic: truncation toward zero. r takes the sign of n, with |r| < |d|. |n| is held as an NSIZE-bit unsigned value, so n = -2^(NSIZE-1) is exact.
- Divide by zero: div_zero=1 and r = n[DSIZE-1:0].
  - SIGNED: q = max positive if n ≥ 0, min negative if n < 0.
  - Unsigned: q = all ones.
- Overflow (SIGNED, n = min negative, d = -1): q = max positive, r = 0, ovf=1.
- in_valid is ignored outside IDLE. Operands need only be stable in the accept cycle.

## Timing
- Normal division: out_valid rises after the (NSIZE+1)th ce-high rising edge following the accept edge (33 for defaults).
- Divide by zero: out_valid rises after the 1st ce-high edge following the accept edge.
- Each ce-low cycle extends latency by one cycle.
- Throughput: one division per NSIZE+3 cycles with out_ready tied high. in_ready and out_valid are never both high.
- rst_n asserted at any time, including mid-CALC: asynchronously returns to IDLE with the reset values above. The in-flight operation is discarded.

## Configuration
- QUOT_ROUND_EN defined: FIX rounds half away from zero.
  - If 2·|r| ≥ |d|, then |q| += 1 and r = n − q·d (r may now differ in sign from n).
  - If incrementing |q| would exceed the signed/unsigned range, q saturates and ovf=1.
  - Latency is unchanged.
- QUOT_ROUND_EN undefined: truncation only; rounding logic is absent.

## Structure
- Shared package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the counter width function clog2(NSIZE);
  - max/min saturation constant helpers.
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, |d|.
  - Outputs: new remainder, quotient bit.
  - Instantiated once in quotient_div.

## Test plan
- n=1000, d=7 → q=142, r=6, out_valid after edge 33. With QUOT_ROUND_EN: q=143, r=-1.
- n=-1000, d=7 → q=-142, r=-6. Also n=1000, d=-7 → q=-142, r=6.
- d=0: n=5 → q=0x7FFFFFFF, r=5, div_zero=1. n=-5 → q=0x80000000, div_zero=1. out_valid after edge 1 in both cases.
- n=0x80000000, d=-1 → q=0x7FFFFFFF, r=0, ovf=1. Also n=0x80000000, d=1 → q=0x80000000, ovf=0.
- Backpressure and ce:
  - out_ready held low 5 cycles → q/r/flags stable and in_ready=0; in_valid pulses during that window are ignored.
  - ce low 4 cycles mid-CALC → out_valid delayed to edge 37.
- rst_n pulsed low at edge 10 of CALC → out_valid=0 and in_ready=1 immediately. The next division, n=100 and d=3, yields q=33, r=1.
